// File: rtl/fifo_level_if.sv
// fifo_level_if: bus bundle between the command producers/consumer and the
// fifo_level block.
//   Write side : i_Data_Valid, i_Data, o_Full, o_Almost_Full
//   Read side  : i_Read, o_Data, o_Empty, o_Almost_Empty
//   Status     : o_Level, o_Overflow, o_Underflow
//   Control    : i_Clear (synchronous flush)
// The master modport is the producer/consumer view; slave is the FIFO view.
interface fifo_level_if #(
  parameter int DATA_WIDTH  = 17,
  parameter int LEVEL_WIDTH = 4
);
  logic                   i_Clear;
  logic                   i_Data_Valid;
  logic [DATA_WIDTH-1:0]  i_Data;
  logic                   o_Full;
  logic                   o_Almost_Full;
  logic                   i_Read;
  logic [DATA_WIDTH-1:0]  o_Data;
  logic                   o_Empty;
  logic                   o_Almost_Empty;
  logic [LEVEL_WIDTH-1:0] o_Level;
  logic                   o_Overflow;
  logic                   o_Underflow;

  modport master (
    output i_Clear, i_Data_Valid, i_Data, i_Read,
    input  o_Full, o_Almost_Full, o_Data, o_Empty, o_Almost_Empty,
           o_Level, o_Overflow, o_Underflow
  );

  modport slave (
    input  i_Clear, i_Data_Valid, i_Data, i_Read,
    output o_Full, o_Almost_Full, o_Data, o_Empty, o_Almost_Empty,
           o_Level, o_Overflow, o_Underflow
  );
endinterface

// File: rtl/fifo_level.sv
// fifo_level: synchronous show-ahead FIFO of arbitrary depth with occupancy
// count, programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
// Ports:
//   i_Clk   : clock, all state changes on posedge
//   i_Rst_N : asynchronous active-low reset (pointers, level, flags)
//   bus     : fifo_level_if slave modport (write/read handshake + status)
module fifo_level #(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 17,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int LEVEL_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic         i_Clk,
  input  logic         i_Rst_N,
  fifo_level_if.slave  bus
);

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]  rptr_q, rptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   full, empty;
  logic                   wr_req_ok, rd_req_ok;
  logic                   wr_en, rd_en;

  // DEPTH need not be a power of two, so wrap by explicit compare.
  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    if (p == ADDR_WIDTH'(DEPTH - 1)) return '0;
    else                             return p + 1'b1;
  endfunction

  // All flags decode from the registered level so they move together.
  assign full  = (level_q == LEVEL_WIDTH'(DEPTH));
  assign empty = (level_q == '0);

  // A write into a full FIFO is accepted when a read frees a slot in the same
  // cycle; a read of an empty FIFO is never accepted, even with a write.
  assign wr_req_ok = bus.i_Data_Valid && (!full || bus.i_Read);
  assign rd_req_ok = bus.i_Read && !empty;
  // Flush drops any concurrent transfer.
  assign wr_en = wr_req_ok && !bus.i_Clear;
  assign rd_en = rd_req_ok && !bus.i_Clear;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (bus.i_Clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_en) wptr_d = next_ptr(wptr_q);
      if (rd_en) rptr_d = next_ptr(rptr_q);
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (bus.i_Data_Valid && !wr_req_ok) ovf_d = 1'b1;
      if (bus.i_Read && !rd_req_ok)       unf_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_Clk) begin
    if (wr_en) mem_q[wptr_q] <= bus.i_Data;
  end

  assign bus.o_Data         = mem_q[rptr_q];
  assign bus.o_Full         = full;
  assign bus.o_Empty        = empty;
  assign bus.o_Almost_Full  = (level_q >= LEVEL_WIDTH'(AFULL_LEVEL));
  assign bus.o_Almost_Empty = (level_q <= LEVEL_WIDTH'(AEMPTY_LEVEL));
  assign bus.o_Level        = level_q;
  assign bus.o_Overflow     = ovf_q;
  assign bus.o_Underflow    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: self-checking bench for fifo_level at DEPTH=5 with a
// queue-based scoreboard and a small reference model of level and flags.
module tb_fifo_level;
  localparam int DEPTH  = 5;
  localparam int DW     = 17;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int AFULL  = DEPTH - 1;
  localparam int AEMPTY = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [DW-1:0] sb_q[$];
  logic          m_ovf, m_unf;

  fifo_level_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) fifo_if ();

  fifo_level #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_N (rst_n),
    .bus     (fifo_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int lvl;
    lvl = sb_q.size();
    chk("level",        32'(fifo_if.o_Level),        32'(lvl));
    chk("empty",        32'(fifo_if.o_Empty),        32'(lvl == 0));
    chk("full",         32'(fifo_if.o_Full),         32'(lvl == DEPTH));
    chk("almost_full",  32'(fifo_if.o_Almost_Full),  32'(lvl >= AFULL));
    chk("almost_empty", 32'(fifo_if.o_Almost_Empty), 32'(lvl <= AEMPTY));
    chk("overflow",     32'(fifo_if.o_Overflow),     32'(m_ovf));
    chk("underflow",    32'(fifo_if.o_Underflow),    32'(m_unf));
    if (lvl != 0) chk("head", 32'(fifo_if.o_Data), 32'(sb_q[0]));
  endtask

  // Called at a negedge: drive one cycle of requests, update the model,
  // cross the posedge and check at the following negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    logic wr, rd;
    fifo_if.i_Data_Valid = v;
    fifo_if.i_Data       = d;
    fifo_if.i_Read       = r;
    fifo_if.i_Clear      = c;
    #1;
    if (c) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      wr = v && (sb_q.size() != DEPTH || r);
      rd = r && (sb_q.size() != 0);
      if (rd) chk("pop_data", 32'(fifo_if.o_Data), 32'(sb_q.pop_front()));
      if (wr) sb_q.push_back(d);
      if (v && !wr) m_ovf = 1'b1;
      if (r && !rd) m_unf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    rst_n = 1'b0;
    fifo_if.i_Data_Valid = 1'b0;
    fifo_if.i_Data       = '0;
    fifo_if.i_Read       = 1'b0;
    fifo_if.i_Clear      = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #2;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_state();

    // Fill to full
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    // Write into full: dropped, overflow sticky
    step(1'b1, 17'h1FFFF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    // Drain
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    // Empty with read+write: write lands, underflow set
    step(1'b1, 17'h0ABCD, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous read/write
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(17'h100 + i), 1'b0, 1'b0);
    step(1'b1, 17'h12345, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Wrap-around stream of 23 words, level held at 2..3
    step(1'b1, 17'h00200, 1'b0, 1'b0);
    step(1'b1, 17'h00201, 1'b0, 1'b0);
    for (int i = 2; i < 23; i++) begin
      if (i == 10) step(1'b1, DW'(17'h200 + i), 1'b0, 1'b0);
      else         step(1'b1, DW'(17'h200 + i), 1'b1, 1'b0);
    end
    while (sb_q.size() != 0) step(1'b0, '0, 1'b1, 1'b0);

    // Clear at level 3 with overflow set and a concurrent write
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(17'h300 + i), 1'b0, 1'b0);
    step(1'b1, 17'h1FFFF, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 17'h0DEAD, 1'b0, 1'b1);
    step(1'b1, 17'h00401, 1'b0, 1'b0);
    step(1'b1, 17'h00402, 1'b1, 1'b0);
    step(1'b1, 17'h00403, 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    fifo_if.i_Data_Valid = 1'b0;
    fifo_if.i_Read       = 1'b0;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 17'h00555, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
